// File: rtl/sound_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sound_pkg                                                            |
// | Clip indices, ROM clip map and sequencer state encoding.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sound_pkg;

   localparam logic [1:0] CLIP_WIN    = 2'd0;
   localparam logic [1:0] CLIP_DETECT = 2'd1;
   localparam logic [1:0] CLIP_CHEER  = 2'd2;
   localparam logic [1:0] CLIP_MOO    = 2'd3;

   localparam logic [17:0] WIN_START    = 18'd0;
   localparam logic [17:0] WIN_END      = 18'd16395;
   localparam logic [17:0] MOO_START    = 18'd16396;
   localparam logic [17:0] MOO_END      = 18'd66982;
   localparam logic [17:0] DETECT_START = 18'd66983;
   localparam logic [17:0] DETECT_END   = 18'd83254;
   localparam logic [17:0] CHEER_START  = 18'd83255;
   localparam logic [17:0] CHEER_END    = 18'd137138;

   // Packed by clip index: slice [i*18 +: 18] belongs to clip i.
   localparam logic [71:0] CLIP_START_DEF = {MOO_START, CHEER_START, DETECT_START, WIN_START};
   localparam logic [71:0] CLIP_END_DEF   = {MOO_END,   CHEER_END,   DETECT_END,   WIN_END};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2,
      ST_PACE    = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sound_clip_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sound_clip_sequencer_if                                              |
// | Event requests, ROM port and audio-controller handshake bundle.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface sound_clip_sequencer_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 6
);
   logic [3:0]        req;
   logic              stop;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q;
   logic [31:0]       sample_out;
   logic              sample_valid;
   logic              sample_ready;
   logic              busy;
   logic [1:0]        active_clip;
   logic              clip_done;

   modport master (
      input  req, stop, rom_q, sample_ready,
      output rom_addr, sample_out, sample_valid, busy, active_clip, clip_done
   );

   modport slave (
      output req, stop, rom_q, sample_ready,
      input  rom_addr, sample_out, sample_valid, busy, active_clip, clip_done
   );
endinterface
`default_nettype wire

// File: rtl/clip_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clip_arbiter                                                         |
// | Fixed-priority encoder over pending clips, lowest index wins.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clip_arbiter (
   input  logic [3:0] i_pending,
   input  logic [1:0] i_active,
   output logic [1:0] o_grant_idx,
   output logic       o_grant_vld,
   output logic       o_higher
);
   always_comb begin
      o_grant_idx = 2'd0;
      o_grant_vld = |i_pending;
      o_higher    = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (i_pending[i]) o_grant_idx = 2'(i);
      end
      for (int i = 0; i < 4; i++) begin
         if (i_pending[i] && (i < int'(i_active))) o_higher = 1'b1;
      end
   end
endmodule
`default_nettype wire

// File: rtl/sound_clip_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sound_clip_sequencer                                                 |
// | Arbitrates clip requests and streams ROM samples at the sample rate. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sound_clip_sequencer
   import sound_pkg::*;
#(
   parameter int                  ADDR_W     = 18,
   parameter int                  DATA_W     = 6,
   parameter int                  SAMPLE_DIV = 1200,
   parameter int                  ROM_LAT    = 2,
   parameter logic [4*ADDR_W-1:0] CLIP_START = CLIP_START_DEF,
   parameter logic [4*ADDR_W-1:0] CLIP_END   = CLIP_END_DEF
) (
   input  logic                   CLOCK_50,
   input  logic                   resetn,
   sound_clip_sequencer_if.master bus
);
   localparam int c_DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int c_LAT_W = $clog2(ROM_LAT + 1);

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_pending, w_pending_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [DATA_W-1:0]   r_q, w_q_nxt;
   logic                r_valid, w_valid_nxt;
   logic                r_busy, w_busy_nxt;
   logic [1:0]          r_active, w_active_nxt;
   logic                r_done, w_done_nxt;
   logic [c_DIV_W-1:0]  r_div, w_div_nxt;
   logic [c_LAT_W-1:0]  r_lat, w_lat_nxt;

   logic [1:0]          w_grant_idx;
   logic                w_grant_vld;
   logic                w_higher;
   logic [3:0]          w_grant_mask;
   logic [ADDR_W-1:0]   w_grant_start;
   logic [ADDR_W-1:0]   w_active_end;
   logic                w_wrap;
   logic                w_fetch_done;

   clip_arbiter u_arb (
      .i_pending   (r_pending),
      .i_active    (r_active),
      .o_grant_idx (w_grant_idx),
      .o_grant_vld (w_grant_vld),
      .o_higher    (w_higher)
   );

   assign w_grant_mask  = 4'b0001 << w_grant_idx;
   assign w_grant_start = CLIP_START[int'(w_grant_idx)*ADDR_W +: ADDR_W];
   assign w_active_end  = CLIP_END[int'(r_active)*ADDR_W +: ADDR_W];
   assign w_wrap        = (r_div == c_DIV_W'(SAMPLE_DIV - 1));
   // rom_q is stable one cycle after the ROM's own latency has elapsed.
   assign w_fetch_done  = (r_lat == c_LAT_W'(ROM_LAT));

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.stop) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:    if (w_grant_vld)      w_state_nxt = ST_FETCH;
            ST_FETCH:   if (w_fetch_done)     w_state_nxt = ST_PRESENT;
            ST_PRESENT: if (bus.sample_ready) w_state_nxt = ST_PACE;
            ST_PACE:    if (w_wrap)           w_state_nxt = (r_addr == w_active_end) ? ST_IDLE : ST_FETCH;
            default:                          w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_pending_nxt = r_pending | bus.req;
      w_addr_nxt    = r_addr;
      w_q_nxt       = r_q;
      w_valid_nxt   = r_valid;
      w_busy_nxt    = r_busy;
      w_active_nxt  = r_active;
      w_done_nxt    = 1'b0;
      w_div_nxt     = (r_busy && !w_wrap) ? r_div + 1'b1 : '0;
      w_lat_nxt     = (r_state == ST_FETCH && !w_fetch_done) ? r_lat + 1'b1 : '0;
      if (bus.stop) begin
         w_pending_nxt = 4'b0000;
         w_valid_nxt   = 1'b0;
         w_busy_nxt    = 1'b0;
         w_div_nxt     = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_vld) begin
                  w_pending_nxt = (r_pending & ~w_grant_mask) | bus.req;
                  w_addr_nxt    = w_grant_start;
                  w_active_nxt  = w_grant_idx;
                  w_busy_nxt    = 1'b1;
               end
            end
            ST_FETCH: begin
               if (w_fetch_done) begin
                  w_q_nxt     = bus.rom_q;
                  w_valid_nxt = 1'b1;
               end
            end
            ST_PRESENT: begin
               if (bus.sample_ready) w_valid_nxt = 1'b0;
            end
            ST_PACE: begin
               if (w_wrap) begin
                  if (r_addr == w_active_end) begin
                     w_done_nxt = 1'b1;
                     w_busy_nxt = 1'b0;
                  end else if (w_higher) begin
                     // Preempted clip is abandoned without a done pulse.
                     w_pending_nxt = (r_pending & ~w_grant_mask) | bus.req;
                     w_addr_nxt    = w_grant_start;
                     w_active_nxt  = w_grant_idx;
                  end else begin
                     w_addr_nxt = r_addr + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         r_pending <= 4'b0000;
         r_addr    <= '0;
         r_q       <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_active  <= 2'd0;
         r_done    <= 1'b0;
         r_div     <= '0;
         r_lat     <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         r_addr    <= w_addr_nxt;
         r_q       <= w_q_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= w_busy_nxt;
         r_active  <= w_active_nxt;
         r_done    <= w_done_nxt;
         r_div     <= w_div_nxt;
         r_lat     <= w_lat_nxt;
      end
   end

   assign bus.rom_addr     = r_addr;
   assign bus.sample_out   = {r_q, {(32-DATA_W){1'b0}}};
   assign bus.sample_valid = r_valid;
   assign bus.busy         = r_busy;
   assign bus.active_clip  = r_active;
   assign bus.clip_done    = r_done;
endmodule
`default_nettype wire

// File: tb/tb_sound_clip_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sound_clip_sequencer                                              |
// | Scoreboard bench with a scaled clip map and a 2-cycle ROM model.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sound_clip_sequencer;
   localparam int ADDR_W     = 18;
   localparam int DATA_W     = 6;
   localparam int SAMPLE_DIV = 8;
   // Scaled map, same ROM ordering: win 0..9, moo 10..29, detect 30..37, cheer 38..49.
   localparam logic [4*ADDR_W-1:0] TB_START = {18'd10, 18'd38, 18'd30, 18'd0};
   localparam logic [4*ADDR_W-1:0] TB_END   = {18'd29, 18'd49, 18'd37, 18'd9};

   logic clk = 1'b0;
   logic resetn;
   always #10 clk = ~clk;

   sound_clip_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sound_clip_sequencer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .SAMPLE_DIV (SAMPLE_DIV),
      .ROM_LAT    (2),
      .CLIP_START (TB_START),
      .CLIP_END   (TB_END)
   ) dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .bus      (bus)
   );

   logic [5:0] rom_d1;
   always @(posedge clk) begin
      rom_d1    <= bus.rom_addr[5:0];
      bus.rom_q <= rom_d1;
   end

   typedef struct {
      bit is_done;
      int addr;
      int clip;
      int gap;
   } ev_t;

   ev_t    sb[$];
   int     n_chk  = 0;
   int     n_fail = 0;
   longint cyc    = 0;
   longint last_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_run(input int clip, input int a0, input int a1, input int g0, input bit done);
      for (int a = a0; a <= a1; a++) sb.push_back('{1'b0, a, clip, (a == a0) ? g0 : SAMPLE_DIV});
      if (done) sb.push_back('{1'b1, 0, clip, 0});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req(input logic [3:0] r);
      bus.req = r;
      tick();
      bus.req = 4'b0000;
   endtask

   task automatic wait_addr(input int a, input int lim);
      for (int i = 0; i < lim; i++) begin
         if (bus.busy && bus.rom_addr == ADDR_W'(a)) break;
         tick();
      end
      chk("wait_addr", 64'(bus.rom_addr), 64'(a));
   endtask

   task automatic wait_valid(input int lim);
      for (int i = 0; i < lim; i++) begin
         if (bus.sample_valid) break;
         tick();
      end
      chk("wait_valid", 64'(bus.sample_valid), 64'd1);
   endtask

   task automatic wait_drain(input int lim);
      for (int i = 0; i < lim; i++) begin
         if (sb.size() == 0 && !bus.busy) break;
         tick();
      end
      chk("drain_queue", 64'(sb.size()), 64'd0);
      chk("drain_busy", 64'(bus.busy), 64'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
      chk({tag, "_sample_out"}, 64'(bus.sample_out), 64'd0);
      chk({tag, "_sample_valid"}, 64'(bus.sample_valid), 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_active_clip"}, 64'(bus.active_clip), 64'd0);
      chk({tag, "_clip_done"}, 64'(bus.clip_done), 64'd0);
   endtask

   // Monitor: every accepted sample and every done pulse pops one expectation.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1) begin
            if (bus.sample_valid && bus.sample_ready) begin
               chk("sb_has_sample", 64'(sb.size() > 0), 64'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("ev_is_sample", 64'(e.is_done), 64'd0);
                  chk("sample_addr", 64'(bus.rom_addr), 64'(e.addr));
                  chk("sample_out", 64'(bus.sample_out), 64'({e.addr[5:0], 26'b0}));
                  chk("sample_clip", 64'(bus.active_clip), 64'(e.clip));
                  if (e.gap != 0) chk("sample_gap", 64'(cyc - last_acc), 64'(e.gap));
               end
               last_acc = cyc;
            end
            if (bus.clip_done) begin
               chk("sb_has_done", 64'(sb.size() > 0), 64'd1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("ev_is_done", 64'(e.is_done), 64'd1);
                  chk("done_clip", 64'(bus.active_clip), 64'(e.clip));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn           = 1'b0;
      bus.req          = 4'b0000;
      bus.stop         = 1'b0;
      bus.sample_ready = 1'b1;
      repeat (3) tick();
      chk_reset_outputs("por");
      resetn = 1'b1;
      tick();

      // Reset while a sample is presented, with moo also pending.
      bus.sample_ready = 1'b0;
      pulse_req(4'b0001);
      pulse_req(4'b1000);
      wait_valid(20);
      chk("mid_rom_addr", 64'(bus.rom_addr), 64'd0);
      resetn = 1'b0;
      tick();
      chk_reset_outputs("mid");
      resetn = 1'b1;
      repeat (20) tick();
      chk("mid_stays_idle", 64'(bus.busy), 64'd0);
      bus.sample_ready = 1'b1;

      // Full win clip at one sample per SAMPLE_DIV.
      push_run(0, 0, 9, 0, 1'b1);
      pulse_req(4'b0001);
      wait_drain(400);

      // Simultaneous detect + moo: detect first, moo follows unprompted.
      push_run(1, 30, 37, 0, 1'b1);
      push_run(3, 10, 29, 0, 1'b1);
      pulse_req(4'b1010);
      wait_drain(800);

      // Win preempts moo after address 15; moo is dropped silently.
      push_run(3, 10, 15, 0, 1'b0);
      push_run(0, 0, 9, SAMPLE_DIV, 1'b1);
      pulse_req(4'b1000);
      wait_addr(15, 200);
      pulse_req(4'b0001);
      wait_drain(400);

      // Re-requesting the active clip replays it afterwards.
      push_run(0, 0, 9, 0, 1'b1);
      push_run(0, 0, 9, 0, 1'b1);
      pulse_req(4'b0001);
      wait_addr(3, 100);
      pulse_req(4'b0001);
      wait_drain(600);

      // Back-pressure on the first cheer sample for 30 cycles.
      bus.sample_ready = 1'b0;
      push_run(2, 38, 38, 0, 1'b0);
      push_run(2, 39, 39, 0, 1'b0);
      push_run(2, 40, 49, SAMPLE_DIV, 1'b1);
      pulse_req(4'b0100);
      wait_valid(20);
      for (int i = 0; i < 30; i++) begin
         tick();
         chk("bp_valid", 64'(bus.sample_valid), 64'd1);
         chk("bp_sample_out", 64'(bus.sample_out), 64'h0000_0000_9800_0000);
      end
      bus.sample_ready = 1'b1;
      wait_drain(400);

      // Stop during cheer with moo pending; a win request alongside stop is dropped.
      push_run(2, 38, 39, 0, 1'b0);
      pulse_req(4'b0100);
      tick();
      pulse_req(4'b1000);
      wait_addr(40, 100);
      bus.stop = 1'b1;
      bus.req  = 4'b0001;
      tick();
      bus.stop = 1'b0;
      bus.req  = 4'b0000;
      chk("stop_busy", 64'(bus.busy), 64'd0);
      chk("stop_valid", 64'(bus.sample_valid), 64'd0);
      repeat (40) tick();
      chk("stop_stays_idle", 64'(bus.busy), 64'd0);
      chk("stop_queue", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
